// File: rtl/nios_onchip_pkg.sv
// nios_onchip_pkg
// Shared types and helpers for the pipelined on-chip RAM slave.
//   state_t  : controller state (RST, CLEAR, READY), 2 bits
//   LAT_MIN  : shortest supported read latency (cycles)
//   LAT_MAX  : longest supported read latency (cycles)
//   parity8  : even-parity bit for one byte, used when ONCHIP_RAM_PARITY_EN is defined
package nios_onchip_pkg;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;

    // Returns the bit that makes the 9-bit {parity, byte} group even.
    function automatic logic parity8(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/nios_system_onchip_ram_array.sv
// onchip_ram_array
// Inferred single-port RAM with per-lane write enables, clock enable and
// unregistered (combinational) read. Lane i occupies bits [i*LANE_W +: LANE_W].
// Ports:
//   clk    in   clock
//   clken  in   clock enable; low blocks every write
//   addr   in   word address (shared by read and write)
//   we     in   per-lane write enable
//   wdata  in   write word
//   rdata  out  word currently stored at addr
module onchip_ram_array #(
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      clken,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [LANES-1:0]          we,
    input  logic [LANES*LANE_W-1:0]   wdata,
    output logic [LANES*LANE_W-1:0]   rdata
);

    logic [LANES*LANE_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; a reset loop over every word
    // would stop it mapping onto block RAM. The controller zero-fills instead.
    always_ff @(posedge clk) begin
        if (clken) begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) begin
                    mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/nios_system_onchip_ram_pipe.sv
// nios_system_onchip_ram_pipe
// Avalon-MM pipelined slave around a parametrised on-chip RAM, with a post-reset
// zero-fill sequence and a read latency of 1 or 2 cycles (counted in enabled cycles).
// Optional feature macro: ONCHIP_RAM_PARITY_EN (per-byte even parity, adds
// inject_parity_err input and parity_error output).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   reset_req, clken        freeze controls; en = clken & ~reset_req
//   address, chipselect,
//   read, write,
//   byteenable, writedata   Avalon-MM command
//   readdata, readdatavalid read response
//   waitrequest             high = command not accepted this cycle
//   init_done               high once the zero-fill has completed
module nios_system_onchip_ram_pipe
    import nios_onchip_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4096,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  clken,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     writedata,
`ifdef ONCHIP_RAM_PARITY_EN
    input  logic                  inject_parity_err,
    output logic                  parity_error,
`endif
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  init_done
);

    localparam int LANES = DATA_W / 8;
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif
    localparam int WORD_W = LANES * LANE_W;

    logic                en;
    logic                accept_rd;
    logic                accept_wr;
    state_t              state;
    logic [ADDR_W-1:0]   cnt;

    logic [ADDR_W-1:0]   mem_addr;
    logic [LANES-1:0]    mem_we;
    logic [WORD_W-1:0]   mem_wdata;
    logic [WORD_W-1:0]   wr_word;
    logic [WORD_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rd_data;

    logic                v1;
    logic [DATA_W-1:0]   d1;
    logic                v_out;

    assign en          = clken & ~reset_req;
    assign waitrequest = (state != READY) | ~en;
    assign init_done   = (state == READY);
    // Write wins over a simultaneous read; the read is dropped entirely.
    assign accept_wr   = chipselect & write & ~waitrequest;
    assign accept_rd   = chipselect & read & ~write & ~waitrequest;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST;
            cnt   <= '0;
        end else if (en) begin
            unique case (state)
                RST:     state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= READY;
                    end
                end
                READY:   state <= READY;
                default: state <= RST;
            endcase
        end
    end

    // Pack write data into storage lanes; with parity each lane is {p, byte}.
    // NOTE: combinational blocks assign every output a default first so no
    // path leaves a variable unassigned and infers a latch.
    always_comb begin
        wr_word = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_word[i*LANE_W +: 8] = writedata[i*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
            wr_word[i*LANE_W + 8] = parity8(writedata[i*8 +: 8]) ^ inject_parity_err;
`endif
        end
    end

    // During the fill the counter owns the port. An all-zero word also carries
    // correct even parity, so no parity special case is needed here.
    always_comb begin
        mem_addr  = address;
        mem_we    = '0;
        mem_wdata = wr_word;
        if (state == CLEAR) begin
            mem_addr  = cnt;
            mem_we    = '1;
            mem_wdata = '0;
        end else if (accept_wr) begin
            mem_we = byteenable;
        end
    end

    onchip_ram_array #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .clken (en),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (mem_wdata),
        .rdata (rd_word)
    );

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_data[i*8 +: 8] = rd_word[i*LANE_W +: 8];
        end
    end

`ifdef ONCHIP_RAM_PARITY_EN
    logic rd_err;
    logic e1;
    logic e_out;

    // Only lanes enabled on the read command are checked.
    always_comb begin
        rd_err = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            rd_err = rd_err | (byteenable[i] &
                     (rd_word[i*LANE_W + 8] != parity8(rd_word[i*LANE_W +: 8])));
        end
    end
`endif

    // First read stage: captures the combinational RAM output at acceptance.
    // The stage holds while en is low, so latency counts enabled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            d1 <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
            e1 <= 1'b0;
`endif
        end else if (en) begin
            v1 <= accept_rd;
            if (accept_rd) begin
                d1 <= rd_data;
`ifdef ONCHIP_RAM_PARITY_EN
                e1 <= rd_err;
`endif
            end
        end
    end

    generate
        if (READ_LATENCY >= LAT_MAX) begin : g_lat2
            logic              v2;
            logic [DATA_W-1:0] d2;
`ifdef ONCHIP_RAM_PARITY_EN
            logic              e2;
`endif
            always_ff @(posedge clk) begin
                if (reset) begin
                    v2 <= 1'b0;
                    d2 <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
                    e2 <= 1'b0;
`endif
                end else if (en) begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= d1;
`ifdef ONCHIP_RAM_PARITY_EN
                        e2 <= e1;
`endif
                    end
                end
            end
            assign v_out    = v2;
            assign readdata = d2;
`ifdef ONCHIP_RAM_PARITY_EN
            assign e_out    = e2;
`endif
        end else begin : g_lat1
            assign v_out    = v1;
            assign readdata = d1;
`ifdef ONCHIP_RAM_PARITY_EN
            assign e_out    = e1;
`endif
        end
    endgenerate

    // A completed result stays parked while frozen and is presented on the
    // first enabled cycle.
    assign readdatavalid = v_out & en;
`ifdef ONCHIP_RAM_PARITY_EN
    assign parity_error  = e_out & readdatavalid;
`endif

endmodule
